// File: rtl/sap1_fetch_addr_seq_if.sv
// Bus between a SAP-1 requester and the fetch/address sequencer.
//   req/mode/operand : access request, fetch (mode=0) or direct (mode=1) address
//   jump/jump_addr   : PC load, honoured only while the sequencer is idle
//   halt             : blocks acceptance of new requests
//   mar_out/pc_out   : address to the ROM decoder, current program counter
//   busy/done        : access in flight / ROM word valid this cycle
//   pc_wrap          : fetch rolled the PC over from all-ones to zero
interface sap1_fetch_addr_seq_if #(
  parameter int ADDR_W = 4
);
  logic              req;
  logic              mode;
  logic [ADDR_W-1:0] operand;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic [ADDR_W-1:0] mar_out;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              done;
  logic              pc_wrap;

  modport master (
    output req, mode, operand, jump, jump_addr, halt,
    input  mar_out, pc_out, busy, done, pc_wrap
  );

  modport slave (
    input  req, mode, operand, jump, jump_addr, halt,
    output mar_out, pc_out, busy, done, pc_wrap
  );
endinterface

// File: rtl/sap1_fetch_addr_seq.sv
// SAP-1 ROM address-generation stage: holds PC and MAR, sequences one ROM
// access per accepted request and drives the MAR into decoder4to16.
//   clock : rising-edge clock
//   reset : synchronous, active-high; returns to idle with PC=MAR=0
//   bus   : slave side of sap1_fetch_addr_seq_if (request, jump, halt in;
//           mar_out, pc_out, busy, done, pc_wrap out)
// Parameters: ADDR_W (MAR/PC width), ROM_LATENCY (1..7 cycles the address is
// held before the ROM word is valid).
module sap1_fetch_addr_seq #(
  parameter int ADDR_W      = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  sap1_fetch_addr_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LAT = 3'(ROM_LATENCY);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [2:0]        cnt;
  logic              done_q;
  logic              wrap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      mar    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // jump wins over a same-cycle request; that request is dropped
          if (bus.jump) begin
            pc <= bus.jump_addr;
          end else if (bus.req && !bus.halt) begin
            cnt   <= LAT;
            state <= S_WAIT;
            if (bus.mode) begin
              mar <= bus.operand;
            end else begin
              mar    <= pc;
              pc     <= pc + 1'b1;
              wrap_q <= &pc;
            end
          end
        end
        S_WAIT: begin
          // done is registered on the WAIT->DONE edge so it is high exactly
          // during the DONE cycle
          if (cnt == 3'd1) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mar_out = mar;
  assign bus.pc_out  = pc;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_q;
  assign bus.pc_wrap = wrap_q;

endmodule

// File: tb/tb_sap1_fetch_addr_seq.sv
// Bench for sap1_fetch_addr_seq: two instances (ROM_LATENCY 1 and 3) share
// stimulus; a timeline model (cycles remaining in the current access) gives
// the expected outputs.
module tb_sap1_fetch_addr_seq;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          i_req, i_mode, i_jump, i_halt;
  logic [AW-1:0] i_op, i_ja;

  sap1_fetch_addr_seq_if #(.ADDR_W(AW)) b1 ();
  sap1_fetch_addr_seq_if #(.ADDR_W(AW)) b3 ();

  assign b1.req = i_req;  assign b1.mode = i_mode; assign b1.operand = i_op;
  assign b1.jump = i_jump; assign b1.jump_addr = i_ja; assign b1.halt = i_halt;
  assign b3.req = i_req;  assign b3.mode = i_mode; assign b3.operand = i_op;
  assign b3.jump = i_jump; assign b3.jump_addr = i_ja; assign b3.halt = i_halt;

  sap1_fetch_addr_seq #(.ADDR_W(AW), .ROM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave));
  sap1_fetch_addr_seq #(.ADDR_W(AW), .ROM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .bus(b3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: index 0 -> latency 1, index 1 -> latency 3
  int unsigned lat    [2] = '{1, 3};
  int unsigned m_pc   [2];
  int unsigned m_mar  [2];
  int unsigned m_left [2];   // cycles still busy with the current access
  bit          m_done [2];
  bit          m_wrap [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = 0; m_mar[k] = 0; m_left[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else begin
        m_done[k] = 0;
        m_wrap[k] = 0;
        if (m_left[k] == 0) begin
          if (i_jump) m_pc[k] = i_ja;
          else if (i_req && !i_halt) begin
            if (i_mode) m_mar[k] = i_op;
            else begin
              m_wrap[k] = (m_pc[k] == 15);
              m_mar[k]  = m_pc[k];
              m_pc[k]   = (m_pc[k] + 1) % 16;
            end
            m_left[k] = lat[k] + 1;
          end
        end else begin
          m_left[k] = m_left[k] - 1;
          m_done[k] = (m_left[k] == 1);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic get_outs(input int k, output logic [AW-1:0] mar, output logic [AW-1:0] pc,
                          output logic busy, output logic done, output logic wrap);
    if (k == 0) begin
      mar = b1.mar_out; pc = b1.pc_out; busy = b1.busy; done = b1.done; wrap = b1.pc_wrap;
    end else begin
      mar = b3.mar_out; pc = b3.pc_out; busy = b3.busy; done = b3.done; wrap = b3.pc_wrap;
    end
  endtask

  task automatic drive(input logic req, input logic mode, input logic [AW-1:0] op,
                       input logic jump, input logic [AW-1:0] ja, input logic halt);
    i_req = req; i_mode = mode; i_op = op; i_jump = jump; i_ja = ja; i_halt = halt;
  endtask

  task automatic settle();
    drive(0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    logic [AW-1:0] mar, pc;
    logic busy, done, wrap;
    reset = 1'b1;
    drive(1, 0, 4'h3, 0, 4'h0, 0);
    step();
    step();
    drive(0, 0, '0, 0, '0, 0);
    reset = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      get_outs(k, mar, pc, busy, done, wrap);
      n_checks++;
      if ({mar, pc, busy, done, wrap} !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: mar=%h pc=%h busy=%b done=%b wrap=%b, required all 0",
                 k, mar, pc, busy, done, wrap);
      end
    end
  endtask

  task automatic test_seq_fetch();
    logic [AW-1:0] mar, pc;
    logic busy, done, wrap;
    int ndone = 0, nwrap = 0, last = 0;
    drive(0, 0, '0, 1, 4'h0, 0);
    step();
    drive(1, 0, '0, 0, '0, 0);
    for (int cyc = 1; cyc <= 48; cyc++) begin
      step();
      get_outs(0, mar, pc, busy, done, wrap);
      if (wrap) nwrap++;
      if (done) begin
        n_checks++;
        if (mar !== AW'(ndone)) begin
          n_fail++;
          $display("FAIL seq_mar: access %0d mar=%h, required %h", ndone, mar, AW'(ndone));
        end
        n_checks++;
        if ((ndone == 0 && cyc != 2) || (ndone != 0 && cyc - last != 3)) begin
          n_fail++;
          $display("FAIL seq_gap: done %0d at cycle %0d, previous %0d", ndone, cyc, last);
        end
        last = cyc;
        ndone++;
      end
    end
    n_checks++;
    if (ndone != 16) begin
      n_fail++;
      $display("FAIL seq_count: %0d done pulses, required 16", ndone);
    end
    n_checks++;
    if (nwrap != 1) begin
      n_fail++;
      $display("FAIL seq_wrap: %0d pc_wrap pulses, required 1", nwrap);
    end
    n_checks++;
    if (b1.pc_out !== 4'h0) begin
      n_fail++;
      $display("FAIL seq_pc_end: pc=%h, required 0", b1.pc_out);
    end
    settle();
  endtask

  task automatic test_direct();
    drive(0, 0, '0, 1, 4'h5, 0);
    step();
    drive(1, 1, 4'hC, 0, '0, 0);
    step();
    drive(0, 0, '0, 0, '0, 0);
    n_checks++;
    if (b1.mar_out !== 4'hC || b3.mar_out !== 4'hC || b1.pc_out !== 4'h5 || b3.pc_out !== 4'h5) begin
      n_fail++;
      $display("FAIL direct_accept: mar=%h/%h pc=%h/%h, required C/C 5/5",
               b1.mar_out, b3.mar_out, b1.pc_out, b3.pc_out);
    end
    step();
    n_checks++;
    if (b1.done !== 1'b1 || b3.done !== 1'b0 || b1.mar_out !== 4'hC) begin
      n_fail++;
      $display("FAIL direct_done1: done=%b/%b mar=%h, required 1/0 C", b1.done, b3.done, b1.mar_out);
    end
    step();
    step();
    n_checks++;
    if (b3.done !== 1'b1 || b3.mar_out !== 4'hC || b3.pc_out !== 4'h5 || b1.pc_out !== 4'h5) begin
      n_fail++;
      $display("FAIL direct_done3: done=%b mar=%h pc=%h/%h, required 1 C 5/5",
               b3.done, b3.mar_out, b1.pc_out, b3.pc_out);
    end
    settle();
  endtask

  task automatic test_jump_priority();
    drive(1, 0, '0, 1, 4'h9, 0);
    step();
    n_checks++;
    if (b1.pc_out !== 4'h9 || b3.pc_out !== 4'h9 || b1.busy !== 1'b0 || b3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_prio: pc=%h/%h busy=%b/%b, required 9/9 0/0",
               b1.pc_out, b3.pc_out, b1.busy, b3.busy);
    end
    drive(1, 0, '0, 0, '0, 0);
    step();
    drive(0, 0, '0, 0, '0, 0);
    n_checks++;
    if (b1.mar_out !== 4'h9 || b1.pc_out !== 4'hA || b1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_fetch: mar=%h pc=%h busy=%b, required 9 A 1",
               b1.mar_out, b1.pc_out, b1.busy);
    end
    settle();
  endtask

  task automatic test_halt_busy();
    drive(0, 0, '0, 1, 4'h3, 0);
    step();
    drive(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (b1.busy !== 1'b0 || b3.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_busy: cycle %0d busy=%b/%b, required 0/0", i, b1.busy, b3.busy);
      end
    end
    drive(1, 0, '0, 0, '0, 0);
    step();                            // acceptance edge E0
    drive(0, 0, '0, 1, 4'hE, 1);       // jump and halt while in flight
    step();                            // E1
    drive(0, 0, '0, 0, '0, 0);
    n_checks++;
    if (b3.pc_out !== 4'h4 || b3.busy !== 1'b1 || b3.done !== 1'b0 || b1.pc_out !== 4'h4) begin
      n_fail++;
      $display("FAIL wait_jump: pc=%h/%h busy=%b done=%b, required 4/4 1 0",
               b1.pc_out, b3.pc_out, b3.busy, b3.done);
    end
    step();                            // E2
    n_checks++;
    if (b3.done !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_early: done=%b at E2, required 0", b3.done);
    end
    step();                            // E3
    n_checks++;
    if (b3.done !== 1'b1 || b3.mar_out !== 4'h3 || b3.pc_out !== 4'h4) begin
      n_fail++;
      $display("FAIL wait_done: done=%b mar=%h pc=%h, required 1 3 4", b3.done, b3.mar_out, b3.pc_out);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    drive(0, 0, '0, 1, 4'h7, 0);
    step();
    drive(1, 0, '0, 0, '0, 0);
    step();
    drive(0, 0, '0, 0, '0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (b3.busy !== 1'b0 || b3.pc_out !== 4'h0 || b3.mar_out !== 4'h0 || b3.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b pc=%h mar=%h done=%b, required 0 0 0 0",
               b3.busy, b3.pc_out, b3.mar_out, b3.done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (b3.done === 1'b1 || b1.done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: %0d done pulses after abort, required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] mar, pc;
    logic busy, done, wrap;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom),
            $urandom_range(0, 5) == 0, AW'($urandom), $urandom_range(0, 3) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        get_outs(k, mar, pc, busy, done, wrap);
        n_checks++;
        if (mar !== AW'(m_mar[k]) || pc !== AW'(m_pc[k]) || busy !== (m_left[k] != 0) ||
            done !== m_done[k] || wrap !== m_wrap[k]) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: mar=%h pc=%h busy=%b done=%b wrap=%b, required mar=%h pc=%h busy=%b done=%b wrap=%b",
                   k, i, mar, pc, busy, done, wrap, AW'(m_mar[k]), AW'(m_pc[k]),
                   m_left[k] != 0, m_done[k], m_wrap[k]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, 0, '0, 0);
    test_reset();
    test_seq_fetch();
    test_direct();
    test_jump_priority();
    test_halt_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
